serializador_8p4: RTL and testbench
===================================

Name: serializador_8p4

Overview:
- Narrowing counterpart of the nRISC 4-to-8 zero extender: accepts 8-bit words and emits them over a 4-bit bus.
- Split mode sends each word as two nibbles. Truncate mode sends only the low nibble and flags any lost upper bits.
- Sits between the 8-bit datapath and 4-bit peripherals/IO ports.
- Valid/ready handshake on both sides; registered outputs.

Parameters:
- ORDEM, 0, nibble order in split mode: 0 = low nibble first, 1 = high nibble first.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low
- modo  input  1  0 = split (two nibbles per word), 1 = truncate (low nibble only); sampled with each accepted word
- entrada  input  8  word to send
- entrada_valida  input  1  entrada holds a valid word
- entrada_pronta  output  1  block accepts a word this cycle
- saida  output  4  current nibble
- saida_valida  output  1  saida holds a valid nibble
- saida_pronta  input  1  consumer accepts the nibble this cycle
- saida_ultimo  output  1  current nibble is the last of its word
- perda  output  1  truncate mode and the upper nibble of the word was non-zero; valid with saida_valida
- contagem  output  8  number of words fully sent, wraps 255->0

Behaviour:
- Handshakes:
  - Input transfer occurs when entrada_valida && entrada_pronta.
  - Output transfer occurs when saida_valida && saida_pronta.
- FSM states:
  - VAZIO: no word held.
  - NIB0: first/only nibble presented.
  - NIB1: second nibble presented.
- State storage: an 8-bit holding register plus a registered copy of modo.
- Reset (reset=0, asynchronous):
  - State goes to VAZIO and the holding register clears to 0.
  - saida=0, saida_valida=0, saida_ultimo=0, perda=0, contagem=0.
  - Reset mid-word discards the held word; contagem is not incremented for it.
- entrada_pronta is combinational:
  - 1 in VAZIO.
  - Also 1 when the final nibble of the current word transfers this cycle (saida_ultimo && saida_valida && saida_pronta).
  - 0 otherwise.
- VAZIO + input transfer: capture the word and modo; next cycle go to NIB0 with saida_valida=1. Latency from acceptance to first nibble = 1 cycle.
- NIB0, split mode:
  - saida = entrada[3:0] if ORDEM=0, else entrada[7:4].
  - saida_ultimo=0, perda=0.
  - On output transfer go to NIB1.
- NIB1, split mode:
  - saida = the other nibble; saida_ultimo=1, perda=0.
  - On output transfer: contagem increments. If a new word transfers in the same cycle, go to NIB0 with the new word; otherwise go to VAZIO with saida_valida=0.
- NIB0, truncate mode:
  - saida = entrada[3:0] regardless of ORDEM; saida_ultimo=1.
  - perda = |entrada[7:4].
  - On output transfer: contagem increments, next state as for NIB1.
- Back-pressure: while saida_pronta=0, saida, saida_valida, saida_ultimo and perda hold stable and entrada_pronta=0.
- Throughput: split mode 1 word per 2 cycles; truncate mode 1 word per cycle.
- modo changes while a word is held do not affect that word.
- Idle outputs: saida_valida=0, saida_ultimo=0, perda=0. saida keeps its last value, except that after reset it is 0.

Test Plan:
- Reset and split mode, ORDEM=0:
  - Release reset; send 0xA5 with modo=0 and saida_pronta=1.
  - Expect saida=0x5 (ultimo=0), then 0xA (ultimo=1); contagem=1; entrada_pronta=0 during NIB0.
- Split mode, ORDEM=1:
  - Send 0x3C.
  - Expect 0x3 then 0xC; perda=0 on both nibbles.
- Truncate mode streaming:
  - Send 0x07, 0x17, 0xF0 on consecutive cycles with modo=1.
  - Expect saida 0x7, 0x7, 0x0 on consecutive cycles, ultimo=1 on each, perda=0,1,1; contagem=3.
- Back-pressure:
  - Send 0x96 in split mode; hold saida_pronta=0 for 3 cycles in NIB0.
  - Expect saida=0x6 stable and entrada_pronta=0; after release, 0x9 follows.
- Back-to-back split words:
  - Send 0x12 then 0x34 with entrada_valida held high.
  - Expect 0x2,0x1,0x4,0x3 on 4 consecutive cycles; entrada_pronta=1 on the cycle 0x1 transfers.
- Reset mid-word and counter wrap:
  - Assert reset while in NIB1: expect immediate saida_valida=0 and contagem=0.
  - Send 256 truncate-mode words: expect contagem wraps to 0.

Source files
------------

// File: rtl/serializador_8p4_if.sv
// rtl/serializador_8p4_if.sv - word input and nibble output handshake bundle
interface serializador_8p4_if;
    logic       modo;
    logic [7:0] entrada;
    logic       entrada_valida;
    logic       entrada_pronta;
    logic [3:0] saida;
    logic       saida_valida;
    logic       saida_pronta;
    logic       saida_ultimo;
    logic       perda;
    logic [7:0] contagem;

    modport master (
        output modo, entrada, entrada_valida, saida_pronta,
        input  entrada_pronta, saida, saida_valida, saida_ultimo, perda, contagem
    );

    modport slave (
        input  modo, entrada, entrada_valida, saida_pronta,
        output entrada_pronta, saida, saida_valida, saida_ultimo, perda, contagem
    );
endinterface

// File: rtl/serializador_8p4.sv
// rtl/serializador_8p4.sv - 8-bit to 4-bit serializer with split and truncate modes
module serializador_8p4 #(
    parameter bit ORDEM = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    serializador_8p4_if.slave bus
);
    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        NIB0  = 2'd1,
        NIB1  = 2'd2
    } estado_t;

    estado_t    estado, estado_nx;
    logic [7:0] palavra, palavra_nx;
    logic       modo_r, modo_nx;
    logic [3:0] saida_r, saida_nx;
    logic       valida_r, valida_nx;
    logic       ultimo_r, ultimo_nx;
    logic       perda_r, perda_nx;
    logic [7:0] contagem_r;
    logic       saida_xfer, fim_xfer, entrada_pronta, entrada_xfer;

    // A new word may enter when idle or when the held word's final nibble leaves now.
    assign saida_xfer     = valida_r && bus.saida_pronta;
    assign fim_xfer       = saida_xfer && ultimo_r;
    assign entrada_pronta = (estado == VAZIO) || fim_xfer;
    assign entrada_xfer   = bus.entrada_valida && entrada_pronta;

    // The output stage looks ahead at the word and mode that will be held next cycle.
    assign palavra_nx = entrada_xfer ? bus.entrada : palavra;
    assign modo_nx    = entrada_xfer ? bus.modo : modo_r;

    // State, holding register, registered outputs and completed-word counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= VAZIO;
            palavra    <= 8'h00;
            modo_r     <= 1'b0;
            saida_r    <= 4'h0;
            valida_r   <= 1'b0;
            ultimo_r   <= 1'b0;
            perda_r    <= 1'b0;
            contagem_r <= 8'h00;
        end else begin
            estado   <= estado_nx;
            palavra  <= palavra_nx;
            modo_r   <= modo_nx;
            saida_r  <= saida_nx;
            valida_r <= valida_nx;
            ultimo_r <= ultimo_nx;
            perda_r  <= perda_nx;
            if (fim_xfer) begin
                contagem_r <= contagem_r + 8'd1;
            end
        end
    end

    // Next state: advance only on an output transfer; reload directly when a word arrives.
    always_comb begin
        estado_nx = estado;
        case (estado)
            VAZIO: begin
                if (entrada_xfer) estado_nx = NIB0;
            end
            NIB0: begin
                if (saida_xfer) begin
                    if (!modo_r)           estado_nx = NIB1;
                    else if (entrada_xfer) estado_nx = NIB0;
                    else                   estado_nx = VAZIO;
                end
            end
            NIB1: begin
                if (saida_xfer) estado_nx = entrada_xfer ? NIB0 : VAZIO;
            end
            default: estado_nx = VAZIO;
        endcase
    end

    // Output values to register, decoded from the next state and the word it will hold.
    always_comb begin
        saida_nx  = saida_r;
        valida_nx = 1'b0;
        ultimo_nx = 1'b0;
        perda_nx  = 1'b0;
        case (estado_nx)
            NIB0: begin
                valida_nx = 1'b1;
                if (modo_nx) begin
                    saida_nx  = palavra_nx[3:0];
                    ultimo_nx = 1'b1;
                    perda_nx  = |palavra_nx[7:4];
                end else begin
                    saida_nx  = ORDEM ? palavra_nx[7:4] : palavra_nx[3:0];
                end
            end
            NIB1: begin
                valida_nx = 1'b1;
                ultimo_nx = 1'b1;
                saida_nx  = ORDEM ? palavra_nx[3:0] : palavra_nx[7:4];
            end
            default: begin
                saida_nx = saida_r;
            end
        endcase
    end

    assign bus.entrada_pronta = entrada_pronta;
    assign bus.saida          = saida_r;
    assign bus.saida_valida   = valida_r;
    assign bus.saida_ultimo   = ultimo_r;
    assign bus.perda          = perda_r;
    assign bus.contagem       = contagem_r;
endmodule

// File: tb/tb_serializador_8p4.sv
// tb/tb_serializador_8p4.sv - self-checking bench for serializador_8p4 (both nibble orders)
module tb_serializador_8p4;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       modo = 1'b0;
    logic [7:0] entrada = 8'h00;
    logic       entrada_valida = 1'b0;
    logic       saida_pronta = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    serializador_8p4_if if0 ();
    serializador_8p4_if if1 ();

    assign if0.modo = modo;
    assign if0.entrada = entrada;
    assign if0.entrada_valida = entrada_valida;
    assign if0.saida_pronta = saida_pronta;
    assign if1.modo = modo;
    assign if1.entrada = entrada;
    assign if1.entrada_valida = entrada_valida;
    assign if1.saida_pronta = saida_pronta;

    serializador_8p4 #(.ORDEM(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(if0));
    serializador_8p4 #(.ORDEM(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(if1));

    always #5 clock = ~clock;

    logic [3:0] d_saida [2];
    logic       d_valida [2];
    logic       d_ultimo [2];
    logic       d_perda [2];
    logic       d_pronta [2];
    logic [7:0] d_cont [2];
    assign d_saida[0] = if0.saida;          assign d_saida[1] = if1.saida;
    assign d_valida[0] = if0.saida_valida;  assign d_valida[1] = if1.saida_valida;
    assign d_ultimo[0] = if0.saida_ultimo;  assign d_ultimo[1] = if1.saida_ultimo;
    assign d_perda[0] = if0.perda;          assign d_perda[1] = if1.perda;
    assign d_pronta[0] = if0.entrada_pronta; assign d_pronta[1] = if1.entrada_pronta;
    assign d_cont[0] = if0.contagem;        assign d_cont[1] = if1.contagem;

    // Model: per DUT, the nibbles of the held word still to be sent, {ultimo, perda, nibble}.
    logic [5:0] pend [2][2];
    int         pend_n [2];
    logic [3:0] last_nib [2];
    int         cnt = 0;

    // Transfer log per DUT: {entrada_pronta, ultimo, perda, nibble} and cycle of each transfer.
    logic [6:0] log0 [$];
    logic [6:0] log1 [$];
    int         logc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void expand(input logic [7:0] w, input logic m, input int o,
                                   output logic [5:0] a, output logic [5:0] b, output int n);
        if (m) begin
            a = {1'b1, |w[7:4], w[3:0]};
            b = 6'h00;
            n = 1;
        end else begin
            a = {2'b00, (o == 1) ? w[7:4] : w[3:0]};
            b = {2'b10, (o == 1) ? w[3:0] : w[7:4]};
            n = 2;
        end
    endfunction

    initial begin : compare
        bit in_x, out_x, exp_pronta;
        logic [5:0] a, b;
        int n;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                for (int k = 0; k < 2; k++) begin
                    pend_n[k] = 0;
                    last_nib[k] = 4'h0;
                    chk($sformatf("rst_valida%0d", k), d_valida[k], 0);
                    chk($sformatf("rst_saida%0d", k), d_saida[k], 0);
                    chk($sformatf("rst_ultimo%0d", k), d_ultimo[k], 0);
                    chk($sformatf("rst_perda%0d", k), d_perda[k], 0);
                    chk($sformatf("rst_contagem%0d", k), d_cont[k], 0);
                end
                cnt = 0;
            end else begin
                exp_pronta = (pend_n[0] == 0) || (pend[0][0][5] && saida_pronta);
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("valida%0d", k), d_valida[k], pend_n[k] > 0);
                    if (pend_n[k] > 0) begin
                        chk($sformatf("saida%0d", k), d_saida[k], pend[k][0][3:0]);
                        chk($sformatf("ultimo%0d", k), d_ultimo[k], pend[k][0][5]);
                        chk($sformatf("perda%0d", k), d_perda[k], pend[k][0][4]);
                    end else begin
                        chk($sformatf("idle_saida%0d", k), d_saida[k], last_nib[k]);
                        chk($sformatf("idle_ultimo%0d", k), d_ultimo[k], 0);
                        chk($sformatf("idle_perda%0d", k), d_perda[k], 0);
                    end
                    chk($sformatf("contagem%0d", k), d_cont[k], cnt % 256);
                    chk($sformatf("entrada_pronta%0d", k), d_pronta[k], exp_pronta);
                end
                out_x = (pend_n[0] > 0) && saida_pronta;
                in_x = entrada_valida && exp_pronta;
                if (out_x) begin
                    log0.push_back({d_pronta[0], d_ultimo[0], d_perda[0], d_saida[0]});
                    log1.push_back({d_pronta[1], d_ultimo[1], d_perda[1], d_saida[1]});
                    logc.push_back(cyc);
                    for (int k = 0; k < 2; k++) begin
                        last_nib[k] = pend[k][0][3:0];
                        if (k == 0 && pend[k][0][5]) cnt++;
                        pend[k][0] = pend[k][1];
                        pend_n[k] = pend_n[k] - 1;
                    end
                end
                if (in_x) begin
                    for (int k = 0; k < 2; k++) begin
                        expand(entrada, modo, k, a, b, n);
                        pend[k][0] = a;
                        pend[k][1] = b;
                        pend_n[k] = n;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] w, input logic m);
        bit ok;
        entrada = w;
        modo = m;
        entrada_valida = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            ok = if0.entrada_pronta;
            @(posedge clock);
            #1;
            if (ok) return;
        end
        chk("send_timeout", 1, 0);
    endtask

    task automatic drain();
        entrada_valida = 1'b0;
        saida_pronta = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        log0.delete();
        log1.delete();
        logc.delete();
    endtask

    task automatic check_log(input string name, input int n, input logic [27:0] e0,
                             input logic [27:0] e1, input bit consec);
        chk({name, "_len0"}, log0.size(), n);
        chk({name, "_len1"}, log1.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < log0.size()) chk($sformatf("%s_d0_%0d", name, i), log0[i], e0[7*i +: 7]);
            if (i < log1.size()) chk($sformatf("%s_d1_%0d", name, i), log1[i], e1[7*i +: 7]);
            if (consec && i > 0 && i < logc.size())
                chk($sformatf("%s_gap%0d", name, i), logc[i] - logc[i-1], 1);
        end
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        clear_log();
        send_word(8'hA5, 1'b0);
        entrada_valida = 1'b0;
        @(negedge clock);
        chk("t1_pronta_nib0", if0.entrada_pronta, 0);
        drain();
        check_log("t1", 2, {14'h0, 7'h6A, 7'h05}, {14'h0, 7'h65, 7'h0A}, 1'b1);
        chk("t1_contagem", if0.contagem, 1);

        clear_log();
        send_word(8'h3C, 1'b0);
        drain();
        check_log("t2", 2, {14'h0, 7'h63, 7'h0C}, {14'h0, 7'h6C, 7'h03}, 1'b1);

        clear_log();
        send_word(8'h07, 1'b1);
        send_word(8'h17, 1'b1);
        send_word(8'hF0, 1'b1);
        drain();
        check_log("t3", 3, {7'h0, 7'h70, 7'h77, 7'h67}, {7'h0, 7'h70, 7'h77, 7'h67}, 1'b1);
        chk("t3_contagem", if1.contagem, 5);

        clear_log();
        saida_pronta = 1'b0;
        send_word(8'h96, 1'b0);
        entrada_valida = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t4_hold_saida", if0.saida, 4'h6);
            chk("t4_hold_pronta", if0.entrada_pronta, 0);
        end
        @(posedge clock);
        #1 saida_pronta = 1'b1;
        drain();
        check_log("t4", 2, {14'h0, 7'h69, 7'h06}, {14'h0, 7'h66, 7'h09}, 1'b1);

        clear_log();
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        drain();
        check_log("t5", 4, {7'h63, 7'h04, 7'h61, 7'h02}, {7'h64, 7'h03, 7'h62, 7'h01}, 1'b1);
        chk("t5_contagem", if0.contagem, 8);

        send_word(8'h55, 1'b0);
        entrada_valida = 1'b0;
        @(posedge clock);
        #1;
        chk("t6_in_nib1", if0.saida_ultimo, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_valida", if0.saida_valida, 0);
        chk("t6_rst_contagem", if0.contagem, 0);
        chk("t6_rst_saida1", if1.saida, 0);
        @(posedge clock);
        #1 reset = 1'b1;

        for (int i = 0; i < 255; i++) send_word(i[7:0], 1'b1);
        drain();
        chk("t7_contagem255", if0.contagem, 255);
        send_word(8'hAB, 1'b1);
        drain();
        chk("t7_wrap", if1.contagem, 0);

        for (int i = 0; i < 3000; i++) begin
            entrada_valida = ($urandom_range(0, 3) != 0);
            entrada = 8'($urandom);
            modo = 1'($urandom_range(0, 1));
            saida_pronta = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
